// File: rtl/codec_init_pkg.sv
// Shared types and constants for the codec register-initialisation sequencer:
// FSM state encoding, timer width and the default codec register table.
package codec_init_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GO,
    WAIT,
    CHECK,
    GAP,
    DONE,
    ERR
  } state_t;

  localparam int TABLE_DEPTH = 16;

  // Wide enough for the largest timeout limit (1023).
  localparam int TIMER_W = 10;

  localparam logic [15:0] REG_TABLE [TABLE_DEPTH] = '{
    16'h0E13, 16'h0579, 16'h0C07, 16'h1001,
    16'h13FF, 16'h0812, 16'h0A00, 16'h1E00,
    16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000
  };

endpackage

// File: rtl/codec_init_timer.sv
// Loadable down-counter shared by the inter-transfer gap and the wait-for-end
// timeout; holds at zero until reloaded.
module codec_init_timer
  import codec_init_pkg::*;
(
  input  logic               clock_20Khz,
  input  logic               pin_reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q, count_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: flops use non-blocking assignment so all registers update together
  // from values sampled before the edge, independent of statement order.
  always_ff @(posedge clock_20Khz or negedge pin_reset) begin
    if (!pin_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/codec_init_seq.sv
// Codec init sequencer: writes the register table to the codec over an I2C
// controller. Define CODEC_INIT_RETRY_EN to retry failed transfers.
module codec_init_seq
  import codec_init_pkg::*;
#(
  parameter int         NUM_REGS       = 10,
  parameter logic [7:0] DEV_ADDR       = 8'h34,
  parameter int         MAX_RETRY      = 3,
  parameter int         GAP_CYCLES     = 4,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter bit         AUTO_START     = 1'b1
) (
  input  logic        clock_20Khz,
  input  logic        pin_reset,
  input  logic        start,
  output logic [23:0] i2c_data,
  output logic        i2c_go,
  input  logic        i2c_end,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        ready,
  output logic        error,
  output logic [3:0]  reg_idx
);

  localparam logic [3:0]         LAST_IDX = 4'(NUM_REGS - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TO_LOAD  = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [23:0] i2c_data_q, i2c_data_d;
  logic        i2c_go_q, i2c_go_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic [3:0]  reg_idx_q, reg_idx_d;
  logic        fail_q, fail_d;
  logic        auto_q, auto_d;
`ifdef CODEC_INIT_RETRY_EN
  logic [2:0]  retry_q, retry_d;
`endif

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_zero;
  logic               start_eff;

  codec_init_timer u_timer (
    .clock_20Khz (clock_20Khz),
    .pin_reset   (pin_reset),
    .load        (tmr_load),
    .load_val    (tmr_val),
    .zero        (tmr_zero)
  );

  // The auto-start flag is set only by reset, so it acts as start for one cycle.
  assign start_eff = start | auto_q;

  always_comb begin
    state_d    = state_q;
    i2c_data_d = i2c_data_q;
    i2c_go_d   = 1'b0;
    busy_d     = busy_q;
    ready_d    = ready_q;
    error_d    = error_q;
    reg_idx_d  = reg_idx_q;
    fail_d     = fail_q;
    auto_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = TO_LOAD;
`ifdef CODEC_INIT_RETRY_EN
    retry_d    = retry_q;
`endif

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_eff) begin
          state_d   = LOAD;
          reg_idx_d = '0;
          ready_d   = 1'b0;
          error_d   = 1'b0;
          busy_d    = 1'b1;
`ifdef CODEC_INIT_RETRY_EN
          retry_d   = '0;
`endif
        end
      end
      LOAD: begin
        i2c_data_d = {DEV_ADDR, REG_TABLE[reg_idx_q]};
        state_d    = GO;
      end
      GO: begin
        i2c_go_d = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = TO_LOAD;
        fail_d   = 1'b0;
        state_d  = WAIT;
      end
      WAIT: begin
        // A completing transfer beats a timeout expiring in the same cycle.
        if (i2c_end) begin
          fail_d  = i2c_nack;
          state_d = CHECK;
        end else if (tmr_zero) begin
          fail_d  = 1'b1;
          state_d = CHECK;
        end else begin
          i2c_go_d = 1'b1;
        end
      end
      CHECK: begin
        if (!fail_q) begin
          if (reg_idx_q == LAST_IDX) begin
            state_d = DONE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            reg_idx_d = reg_idx_q + 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = GAP_LOAD;
            state_d   = GAP;
`ifdef CODEC_INIT_RETRY_EN
            retry_d   = '0;
`endif
          end
        end else begin
`ifdef CODEC_INIT_RETRY_EN
          if (int'(retry_q) < MAX_RETRY) begin
            retry_d  = retry_q + 1'b1;
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
            state_d  = GAP;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end
`else
          state_d = ERR;
          error_d = 1'b1;
          busy_d  = 1'b0;
`endif
        end
      end
      GAP: begin
        if (tmr_zero && !i2c_end) begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_20Khz or negedge pin_reset) begin
    if (!pin_reset) begin
      state_q    <= IDLE;
      i2c_data_q <= '0;
      i2c_go_q   <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      reg_idx_q  <= '0;
      fail_q     <= 1'b0;
      auto_q     <= AUTO_START;
`ifdef CODEC_INIT_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      i2c_data_q <= i2c_data_d;
      i2c_go_q   <= i2c_go_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      reg_idx_q  <= reg_idx_d;
      fail_q     <= fail_d;
      auto_q     <= auto_d;
`ifdef CODEC_INIT_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign i2c_data = i2c_data_q;
  assign i2c_go   = i2c_go_q;
  assign busy     = busy_q;
  assign ready    = ready_q;
  assign error    = error_q;
  assign reg_idx  = reg_idx_q;

endmodule

// File: doc/codec_init_seq.md
CODEC_INIT_SEQ -- requirements
Module: codec_init_seq

Interface
REQ-001 Parameters SHALL be, one per line:
  NUM_REGS 10: table entries sent per sequence, 1..16.
  DEV_ADDR 8'h34: codec I2C write address placed in i2c_data[23:16].
  MAX_RETRY 3: extra attempts per entry after a failure, 0..7.
  GAP_CYCLES 4: idle cycles between transfers, 1..255.
  TIMEOUT_CYCLES 64: wait-for-end limit, 2..1023.
  AUTO_START 1: a sequence starts by itself after reset.
REQ-002 Ports SHALL be, one per line:
  clock_20Khz  in  1   sequencer clock.
  pin_reset    in  1   reset; asynchronous, active-low; clock clock_20Khz.
  start        in  1   level request to (re)run the sequence.
  i2c_data     out 24  {DEV_ADDR, register word[15:0]} to the I2C controller.
  i2c_go       out 1   transfer request.
  i2c_end      in  1   transfer complete.
  i2c_nack     in  1   high at end means any byte was not acknowledged.
  busy         out 1   sequence in progress.
  ready        out 1   all entries written successfully; this drives the LED.
  error        out 1   sequence aborted.
  reg_idx      out 4   current entry index (or failing entry on error).

Function
REQ-003 The states SHALL be IDLE, LOAD, GO, WAIT, CHECK, GAP, DONE and ERR.
REQ-004 IDLE/DONE/ERR -> LOAD when start=1: reg_idx=0, retry count=0, ready=0, error=0, busy=1.
REQ-005 start SHALL be ignored in every other state.
REQ-006 LOAD: i2c_data={DEV_ADDR, table[reg_idx]}, then go to GO.
REQ-007 i2c_data SHALL hold stable from LOAD until the next LOAD.
REQ-008 GO: i2c_go=1, timeout counter=0, go to WAIT.
REQ-009 WAIT: i2c_go SHALL stay 1 until i2c_end=1 is sampled.
REQ-010 On i2c_end=1 in WAIT: latch i2c_nack, deassert i2c_go next cycle, go to CHECK.
REQ-011 If the timeout counter reaches TIMEOUT_CYCLES-1 in WAIT, the transfer SHALL count as failed; i2c_go drops and the state goes to CHECK.
REQ-012 CHECK on success: if reg_idx==NUM_REGS-1 go to DONE, else reg_idx+1, retry=0, go to GAP.
REQ-013 CHECK on failure: see REQ-021/022.
REQ-014 GAP SHALL hold i2c_go=0 for exactly GAP_CYCLES cycles, then go to LOAD.
REQ-015 GAP SHALL also wait until i2c_end=0 before leaving.
REQ-016 DONE: ready=1, busy=0. ERR: error=1, busy=0, reg_idx frozen at the failing entry.
REQ-017 Latency: an all-ACK run with a 1-cycle END response SHALL assert ready exactly NUM_REGS*(5+GAP_CYCLES)-GAP_CYCLES cycles after leaving IDLE.
REQ-018 If i2c_end=1 and the timeout limit occur in the same cycle, i2c_end SHALL win and i2c_nack decides.
REQ-019 A start level held high across DONE SHALL re-run the sequence; this is intended behaviour.

Reset
REQ-020 While pin_reset=0, asynchronously: state=IDLE, i2c_go=0, i2c_data=0, busy=0, ready=0, error=0, reg_idx=0, all counters=0.
REQ-020a Reset asserted mid-transfer SHALL drop i2c_go immediately.
REQ-020b With AUTO_START=1, the first cycle after reset release SHALL behave as start=1.

Configuration
REQ-021 With CODEC_INIT_RETRY_EN defined, a failed transfer with retry<MAX_RETRY SHALL increment retry and go to GAP, then LOAD the same reg_idx.
REQ-021a With CODEC_INIT_RETRY_EN defined, a failure at retry==MAX_RETRY SHALL go to ERR.
REQ-022 Without CODEC_INIT_RETRY_EN, any failure SHALL go directly to ERR, and the retry counter SHALL not exist.

Structure
REQ-023 Package codec_init_pkg SHALL hold the state enum, a 16-entry register table constant and its default contents.
REQ-024 Default table entries 0..7 SHALL be 0E13, 0579, 0C07, 1001, 13FF, 0812, 0A00, 1E00, with the remaining entries zero.
REQ-025 Sub-module codec_init_timer SHALL be a loadable down-counter shared by GAP and the WAIT timeout.

Verification
REQ-026 All-ACK: END model returns END 3 cycles after go, nack=0 -> 10 transfers in table order, i2c_data[23:16]=8'h34 on each, ready=1, error=0.
REQ-027 RETRY_EN, nack=1 on the first two attempts of entry 4 -> entry 4 is sent 3 times, ready=1.
REQ-028 RETRY_EN, nack=1 on every attempt of entry 2 -> 4 attempts, then error=1, reg_idx=2.
REQ-029 No RETRY_EN, same stimulus as REQ-028 -> error after 1 attempt.
REQ-030 END never asserted -> i2c_go high for 64 cycles, then drops, then retry/ERR per macro.
REQ-031 pin_reset pulsed during WAIT of entry 5 -> i2c_go=0 at once; after release AUTO_START restarts from entry 0.
REQ-032 start pulsed while busy -> no effect on sequence or transfer count.
